stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that merges `num_in` upstream bypass-FIFO streams into one downstream FIFO.
- Upstream side: drives each input FIFO's `deq` from its `empty_n` and data.
- Downstream side: drives the output FIFO's `enq` from its `full_n`.
- The data path is combinational, with zero added latency, matching the bypass FIFO's same-cycle semantics.
- Grants can be locked to one input for up to `burst` consecutive words, so multi-word packets from one source stay contiguous.

## Interface
Parameters:
- `width`, 8: data word width.
- `num_in`, 4: number of input streams, ≥ 2.
- `burst`, 4: maximum consecutive transfers per grant, ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset; one clock, polarity and synchronicity fixed.
- `in_empty_n`  in  `num_in`  bit k high: input k has a word available.
- `in_data`  in  `num_in*width`  input k occupies bits `[k*width +: width]`.
- `in_deq`  out  `num_in`  one-hot or zero; pops input k this cycle.
- `out_full_n`  in  1  downstream can accept a word this cycle.
- `out_enq`  out  1  pushes `out_data` downstream this cycle.
- `out_data`  out  `width`  selected word; 0 when no owner is selected.
- `out_src`  out  `clog2(num_in)`  index of the selected input; 0 when none.

## Operation
- State: `st` ∈ {IDLE, LOCKED}, `owner` (clog2(num_in) bits), `ptr` (next-priority index), `cnt` (clog2(burst+1) bits).
- Candidate selection:
  - IDLE: the first k with `in_empty_n[k]` = 1, searching `ptr`, `ptr+1`, … with modulo `num_in` wrap.
  - LOCKED: `owner`, if `in_empty_n[owner]` = 1.
  - Otherwise no candidate exists.
- Transfer condition: a candidate exists AND `out_full_n` AND !`reset`.
  - On transfer: `out_enq` = 1 and `in_deq[cand]` = 1 in the same cycle.
  - Otherwise every `in_deq` = 0 and `out_enq` = 0.
- `out_data` and `out_src` always reflect the candidate, whether or not a transfer happens. This lets downstream observe the head word while stalled.
- Transitions:
  - IDLE, transfer, `burst` = 1: stay IDLE; `ptr` ← cand+1 (mod).
  - IDLE, transfer, `burst` > 1: → LOCKED; `owner` ← cand; `cnt` ← 1.
  - IDLE, no transfer: hold all state, including `ptr`.
  - LOCKED, transfer, `cnt`+1 = `burst`: → IDLE; `ptr` ← `owner`+1.
  - LOCKED, transfer otherwise: `cnt` ← `cnt`+1.
  - LOCKED, `in_empty_n[owner]` = 0: → IDLE; `ptr` ← `owner`+1. A source running dry forfeits its lock.
  - LOCKED, owner has data but `out_full_n` = 0: hold; the stall costs no burst credit.
- Simultaneous requests: only the candidate is dequeued. Other inputs see `in_deq` = 0 and are untouched.
- `ptr` wraps from `num_in`-1 to 0. `cnt` never exceeds `burst`-1 while LOCKED.

## Timing
- Reset values (cycle after `reset` high): `st` = IDLE, `ptr` = 0, `owner` = 0, `cnt` = 0.
- During the `reset` cycle: `in_deq` = 0 and `out_enq` = 0.
- Reset asserted mid-burst drops the lock with no transfer that cycle. The first post-reset grant goes to the lowest-index requester.
- Latency: 0 cycles from input word to `out_enq`. There is no internal storage.
- Arbitration decisions take effect on the next clock edge.
- Throughput: 1 word/cycle. No bubble on rotation between owners, because an IDLE-state candidate transfers in the same cycle it is picked.
- Combinational paths exist from `in_empty_n`/`out_full_n` to `in_deq`/`out_enq`. Integrators must not close a loop through a bypass FIFO on both sides.

## Structure
- Shared package `stream_arb_pkg`:
  - `clog2` function.
  - `st_t` enum {IDLE, LOCKED}.
- Sub-module `rr_pick`: parameterised rotating priority encoder.
  - Inputs: `req[num_in]`, `base`.
  - Outputs: `found`, `idx`.
  - Purely combinational; instantiated once.
- Top level: state registers, transition logic, output muxing.

## Test plan
- Reset, then `in_empty_n` = 4'b1010, `out_full_n` = 1, `burst` = 1: grants alternate 1, 3, 1, 3; `in_deq` one-hot each cycle; `out_data` equals the source word.
- `burst` = 4, all inputs always non-empty: `out_src` sequence is 0,0,0,0,1,1,1,1,2,… at one word/cycle, with no bubbles.
- `burst` = 4, input 2 drains after 2 words (`in_empty_n[2]` falls): lock is released that cycle and `ptr` = 3; the next grant goes to 3 (or 0 if 3 is empty).
- Owner locked, `out_full_n` low for 3 cycles: `out_enq` = 0 and `in_deq` = 0 throughout; `out_src`/`out_data` are held; after release the burst completes with `cnt` unchanged.
- `reset` pulsed while LOCKED with `cnt` = 2 on input 3: the following cycle is IDLE with `ptr` = 0; input 0 is granted if it is requesting.
- No inputs requesting: `out_enq` = 0, `out_data` = 0, `out_src` = 0; `ptr` stays unchanged across 10 idle cycles.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Holds the index-width helper and the two-state arbitration enum.
package stream_arb_pkg;

    // Ceiling log2, floored at 1 so single-bit indices stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } st_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first set request at or after base,
// wrapping modulo num_in. Purely combinational.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int num_in = 4
) (
    input  logic [num_in-1:0]         req,
    input  logic [clog2(num_in)-1:0]  base,
    output logic                      found,
    output logic [clog2(num_in)-1:0]  idx
);

    localparam int IW = clog2(num_in);

    logic [IW:0] pos;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = num_in - 1; i >= 0; i--) begin
            pos = {1'b0, base} + (IW+1)'(i);
            if (pos >= (IW+1)'(num_in)) pos = pos - (IW+1)'(num_in);
            if (req[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of num_in bypass-FIFO streams into one output FIFO,
// zero-latency data path with optional burst locking per grant.
//
// state  | meaning
// IDLE   | no lock; candidate is first requester from ptr, rotating
// LOCKED | owner holds the grant until burst words, dry source, or reset
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int width  = 8,
    parameter int num_in = 4,
    parameter int burst  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [num_in-1:0]           in_empty_n,
    input  logic [num_in*width-1:0]     in_data,
    output logic [num_in-1:0]           in_deq,
    input  logic                        out_full_n,
    output logic                        out_enq,
    output logic [width-1:0]            out_data,
    output logic [clog2(num_in)-1:0]    out_src
);

    localparam int IW = clog2(num_in);
    localparam int CW = clog2(burst + 1);
    localparam logic [CW-1:0] BURST_C = CW'(burst);

    st_t           st_q, st_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          cand_found;
    logic [IW-1:0] cand;
    logic          xfer;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(num_in - 1)) ? '0 : v + IW'(1);
    endfunction

    rr_pick #(
        .num_in (num_in)
    ) u_pick (
        .req   (in_empty_n),
        .base  (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        if (st_q == LOCKED) begin
            cand_found = in_empty_n[owner_q];
            cand       = owner_q;
        end else begin
            cand_found = pick_found;
            cand       = pick_idx;
        end
    end

    assign xfer    = cand_found & out_full_n & ~reset;
    assign out_enq = xfer;
    assign out_src = cand_found ? cand : '0;

    // Data and src follow the candidate even while stalled, so the head word is visible.
    always_comb begin
        out_data = '0;
        in_deq   = '0;
        for (int k = 0; k < num_in; k++) begin
            if (cand_found && (cand == IW'(k))) out_data = in_data[k*width +: width];
            if (xfer && (cand == IW'(k)))       in_deq[k] = 1'b1;
        end
    end

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (st_q == IDLE) begin
            if (xfer) begin
                if (burst == 1) begin
                    ptr_d = wrap_inc(cand);
                end else begin
                    st_d    = LOCKED;
                    owner_d = cand;
                    cnt_d   = CW'(1);
                end
            end
        end else begin
            // A dry owner forfeits its lock; an output stall consumes no credit.
            if (!in_empty_n[owner_q]) begin
                st_d  = IDLE;
                ptr_d = wrap_inc(owner_q);
                cnt_d = '0;
            end else if (xfer) begin
                if ((cnt_q + CW'(1)) == BURST_C) begin
                    st_d  = IDLE;
                    ptr_d = wrap_inc(owner_q);
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: two instances (burst 1 and 4) share
// stimulus; a rule-level model queues expected outputs, a monitor compares.
module tb_stream_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic         enq;
        logic [N-1:0] deq;
        logic [1:0]   src;
        logic [W-1:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   in_empty_n = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_full_n = 1'b0;

    logic [N-1:0]   deq_b1, deq_b4;
    logic           enq_b1, enq_b4;
    logic [W-1:0]   data_b1, data_b4;
    logic [1:0]     src_b1, src_b4;

    exp_t q_b1[$];
    exp_t q_b4[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: locked source (-1 none), words sent in lock, next priority.
    int m_locked[2] = '{-1, -1};
    int m_used[2]   = '{0, 0};
    int m_prio[2]   = '{0, 0};

    always #5 clk = ~clk;

    stream_rr_arbiter #(.width(W), .num_in(N), .burst(1)) u_b1 (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (in_empty_n),
        .in_data    (in_data),
        .in_deq     (deq_b1),
        .out_full_n (out_full_n),
        .out_enq    (enq_b1),
        .out_data   (data_b1),
        .out_src    (src_b1)
    );

    stream_rr_arbiter #(.width(W), .num_in(N), .burst(4)) u_b4 (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (in_empty_n),
        .in_data    (in_data),
        .in_deq     (deq_b4),
        .out_full_n (out_full_n),
        .out_enq    (enq_b4),
        .out_data   (data_b4),
        .out_src    (src_b4)
    );

    task automatic model_step(input int i, input int bl, output exp_t e);
        int cand;
        int k;
        cand = -1;
        if (m_locked[i] >= 0) begin
            if (in_empty_n[m_locked[i]]) cand = m_locked[i];
        end else begin
            for (int j = 0; j < N; j++) begin
                k = (m_prio[i] + j) % N;
                if (cand < 0 && in_empty_n[k]) cand = k;
            end
        end
        e.enq  = (cand >= 0) && out_full_n && !reset;
        e.src  = (cand >= 0) ? 2'(cand) : 2'd0;
        e.data = (cand >= 0) ? in_data[cand*W +: W] : '0;
        e.deq  = e.enq ? N'(1 << cand) : '0;
        if (reset) begin
            m_locked[i] = -1;
            m_used[i]   = 0;
            m_prio[i]   = 0;
        end else if (m_locked[i] >= 0) begin
            if (cand < 0) begin
                m_prio[i]   = (m_locked[i] + 1) % N;
                m_locked[i] = -1;
            end else if (e.enq) begin
                m_used[i]++;
                if (m_used[i] == bl) begin
                    m_prio[i]   = (m_locked[i] + 1) % N;
                    m_locked[i] = -1;
                end
            end
        end else if (e.enq) begin
            if (bl == 1) begin
                m_prio[i] = (cand + 1) % N;
            end else begin
                m_locked[i] = cand;
                m_used[i]   = 1;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] req, input logic full, input logic rst);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        in_empty_n = req;
        out_full_n = full;
        in_data    = $urandom;
        model_step(0, 1, e);
        q_b1.push_back(e);
        model_step(1, 4, e);
        q_b4.push_back(e);
    endtask

    task automatic check(input string nm, input exp_t e, input exp_t a);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t: got enq=%0b deq=%b src=%0d data=%h, expected enq=%0b deq=%b src=%0d data=%h",
                     nm, $time, a.enq, a.deq, a.src, a.data, e.enq, e.deq, e.src, e.data);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q_b1.size() > 0) begin
                e = q_b1.pop_front();
                check("burst1", e, {enq_b1, deq_b1, src_b1, data_b1});
            end
            if (q_b4.size() > 0) begin
                e = q_b4.pop_front();
                check("burst4", e, {enq_b4, deq_b4, src_b4, data_b4});
            end
        end
    end

    initial begin
        // Reset cycles with requests present: nothing may transfer.
        step(4'b0110, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        // Alternating sparse requesters.
        repeat (8) step(4'b1010, 1'b1, 1'b0);
        // Full load: burst-4 rotates 0,0,0,0,1,1,1,1,...
        step(4'b0000, 1'b1, 1'b1);
        repeat (16) step(4'b1111, 1'b1, 1'b0);
        // Input 2 drains after two words; lock drops and 3 is next.
        step(4'b0000, 1'b1, 1'b1);
        repeat (2) step(4'b0100, 1'b1, 1'b0);
        repeat (4) step(4'b1011, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b1);
        repeat (2) step(4'b0100, 1'b1, 1'b0);
        repeat (3) step(4'b0011, 1'b1, 1'b0);
        // Output stall mid-burst holds the lock and burst credit.
        step(4'b0000, 1'b1, 1'b1);
        repeat (2) step(4'b1111, 1'b1, 1'b0);
        repeat (3) step(4'b1111, 1'b0, 1'b0);
        repeat (6) step(4'b1111, 1'b1, 1'b0);
        // Reset while locked on input 3 with two words sent.
        step(4'b0000, 1'b1, 1'b1);
        repeat (2) step(4'b1000, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        repeat (3) step(4'b1001, 1'b1, 1'b0);
        // Idle stretch must not move the pointer.
        repeat (2) step(4'b0100, 1'b1, 1'b0);
        repeat (10) step(4'b0000, 1'b1, 1'b0);
        repeat (6) step(4'b1111, 1'b1, 1'b0);
        // Randomized traffic with occasional stalls and resets.
        for (int c = 0; c < 400; c++) begin
            step(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end
        step(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        #3;
        n_cmp++;
        if (q_b1.size() != 0 || q_b4.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_b1.size(), q_b4.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
